// File: rtl/rv_ctrl_defs.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// datapath select codes and the control-output bundle.
package rv_ctrl_defs;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNC3_W  = 3;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned SEL_W    = 2;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

  localparam logic [FUNC3_W-1:0] FUNC3_SR = 3'b101;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [SEL_W-1:0] ALU_ADD    = 2'b00;
  localparam logic [SEL_W-1:0] ALU_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] ALU_FUNC3  = 2'b10;
  localparam logic [SEL_W-1:0] ALU_JUMP   = 2'b11;

  localparam logic [SEL_W-1:0] PC_PLUS4 = 2'b00;
  localparam logic [SEL_W-1:0] PC_REL   = 2'b01;
  localparam logic [SEL_W-1:0] PC_ALU   = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALU  = 2'b00;
  localparam logic [SEL_W-1:0] RES_MEM  = 2'b01;
  localparam logic [SEL_W-1:0] RES_LINK = 2'b10;

  localparam logic [SEL_W-1:0] SRC_A_RS1   = 2'b00;
  localparam logic [SEL_W-1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRC_A_ZERO  = 2'b10;

  typedef struct packed {
    logic r;
    logic i_alu;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
  } op_class_t;

  typedef struct packed {
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_src;
    logic             ir_write;
    logic             pc_write;
    logic [SEL_W-1:0] pc_src;
    logic [SEL_W-1:0] alu_op;
    logic             alu_sign_en;
    logic [SEL_W-1:0] alu_src_a;
    logic             alu_src_b;
    logic             reg_write;
    logic [SEL_W-1:0] result_src;
    logic             retire;
    logic             trap;
  } ctrl_out_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; master is the control FSM side.
interface multicycle_ctrl_if;
  import rv_ctrl_defs::*;

  logic [OPCODE_W-1:0] opcode;
  logic [FUNC3_W-1:0]  func3;
  logic                alu_flag;
  logic                mem_ready;
  logic                mem_req;
  logic                mem_we;
  logic                mem_addr_src;
  logic                ir_write;
  logic                pc_write;
  logic [SEL_W-1:0]    pc_src;
  logic [SEL_W-1:0]    alu_op;
  logic                alu_sign_en;
  logic [SEL_W-1:0]    alu_src_a;
  logic                alu_src_b;
  logic                reg_write;
  logic [SEL_W-1:0]    result_src;
  logic                retire;
  logic                trap;

  modport master (
    input  opcode, func3, alu_flag, mem_ready,
    output mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src, alu_op,
           alu_sign_en, alu_src_a, alu_src_b, reg_write, result_src, retire, trap
  );

  modport slave (
    output opcode, func3, alu_flag, mem_ready,
    input  mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src, alu_op,
           alu_sign_en, alu_src_a, alu_src_b, reg_write, result_src, retire, trap
  );
endinterface

// File: rtl/opcode_class_dec.sv
// Opcode to one-hot instruction class; illegal when no class matches.
module opcode_class_dec
  import rv_ctrl_defs::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           cls,
  output logic                illegal
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_R:      cls.r      = 1'b1;
      OP_I:      cls.i_alu  = 1'b1;
      OP_LOAD:   cls.load   = 1'b1;
      OP_STORE:  cls.store  = 1'b1;
      OP_BRANCH: cls.branch = 1'b1;
      OP_JAL:    cls.jal    = 1'b1;
      OP_JALR:   cls.jalr   = 1'b1;
      OP_LUI:    cls.lui    = 1'b1;
      OP_AUIPC:  cls.auipc  = 1'b1;
      default:   cls        = '0;
    endcase
  end

  assign illegal = ~|cls;

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: fetch/decode/exec/mem/wb
// sequencing with Mealy-decoded control strobes and a memory req/ready handshake.
module multicycle_ctrl
  import rv_ctrl_defs::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);

  state_t    state, state_next;
  op_class_t cls;
  logic      illegal;
  ctrl_out_t ctrl_c, ctrl;

  opcode_class_dec u_dec (
    .opcode  (bus.opcode),
    .cls     (cls),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ctrl_c     = '0;
    case (state)
      S_FETCH: begin
        ctrl_c.mem_req = 1'b1;
        if (bus.mem_ready) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          ctrl_c.pc_src   = PC_PLUS4;
          state_next      = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!illegal)             state_next = S_EXEC;
        else if (TRAP_ON_ILLEGAL) state_next = S_TRAP;
        else begin
          ctrl_c.retire = 1'b1;
          state_next    = S_FETCH;
        end
      end
      S_EXEC: begin
        if (cls.r) begin
          ctrl_c.alu_op      = ALU_FUNC3;
          ctrl_c.alu_sign_en = 1'b1;
          state_next         = S_WB;
        end else if (cls.i_alu) begin
          ctrl_c.alu_op      = ALU_FUNC3;
          ctrl_c.alu_src_b   = 1'b1;
          ctrl_c.alu_sign_en = (bus.func3 == FUNC3_SR);
          state_next         = S_WB;
        end else if (cls.load || cls.store) begin
          ctrl_c.alu_op    = ALU_ADD;
          ctrl_c.alu_src_b = 1'b1;
          state_next       = S_MEM;
        end else if (cls.branch) begin
          ctrl_c.alu_op = ALU_BRANCH;
          if (bus.alu_flag) begin
            ctrl_c.pc_write = 1'b1;
            ctrl_c.pc_src   = PC_REL;
          end
          ctrl_c.retire = 1'b1;
          state_next    = S_FETCH;
        end else if (cls.jal) begin
          ctrl_c.pc_write = 1'b1;
          ctrl_c.pc_src   = PC_REL;
          state_next      = S_WB;
        end else if (cls.jalr) begin
          ctrl_c.alu_op    = ALU_JUMP;
          ctrl_c.alu_src_b = 1'b1;
          ctrl_c.pc_write  = 1'b1;
          ctrl_c.pc_src    = PC_ALU;
          state_next       = S_WB;
        end else if (cls.lui) begin
          ctrl_c.alu_src_a = SRC_A_ZERO;
          ctrl_c.alu_src_b = 1'b1;
          state_next       = S_WB;
        end else if (cls.auipc) begin
          ctrl_c.alu_src_a = SRC_A_OLDPC;
          ctrl_c.alu_src_b = 1'b1;
          state_next       = S_WB;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_MEM: begin
        ctrl_c.mem_req      = 1'b1;
        ctrl_c.mem_addr_src = 1'b1;
        ctrl_c.mem_we       = cls.store;
        if (bus.mem_ready) begin
          if (cls.store) begin
            ctrl_c.retire = 1'b1;
            state_next    = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.retire    = 1'b1;
        if (cls.load)                ctrl_c.result_src = RES_MEM;
        else if (cls.jal || cls.jalr) ctrl_c.result_src = RES_LINK;
        else                         ctrl_c.result_src = RES_ALU;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        ctrl_c.trap = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Reset forces every strobe low, so an in-flight memory request is dropped at once.
  assign ctrl = rst_n ? ctrl_c : '0;

  assign bus.mem_req      = ctrl.mem_req;
  assign bus.mem_we       = ctrl.mem_we;
  assign bus.mem_addr_src = ctrl.mem_addr_src;
  assign bus.ir_write     = ctrl.ir_write;
  assign bus.pc_write     = ctrl.pc_write;
  assign bus.pc_src       = ctrl.pc_src;
  assign bus.alu_op       = ctrl.alu_op;
  assign bus.alu_sign_en  = ctrl.alu_sign_en;
  assign bus.alu_src_a    = ctrl.alu_src_a;
  assign bus.alu_src_b    = ctrl.alu_src_b;
  assign bus.reg_write    = ctrl.reg_write;
  assign bus.result_src   = ctrl.result_src;
  assign bus.retire       = ctrl.retire;
  assign bus.trap         = ctrl.trap;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle control trace, which is replayed against the DUT.
module tb_multicycle_ctrl;
  import rv_ctrl_defs::*;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       flag;
    logic       ready;
    ctrl_out_t  exp;
  } rec_t;

  rec_t      trace[$];
  int        checks = 0;
  int        errors = 0;
  int        retires = 0;
  int        c;
  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  ctrl_out_t out_n, out_t;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus_n ();
  multicycle_ctrl_if bus_t ();

  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));
  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut_t (.clk(clk), .rst_n(rst_n), .bus(bus_t));

  always_comb begin
    out_n = '0;
    out_n.mem_req = bus_n.mem_req; out_n.mem_we = bus_n.mem_we; out_n.mem_addr_src = bus_n.mem_addr_src;
    out_n.ir_write = bus_n.ir_write; out_n.pc_write = bus_n.pc_write; out_n.pc_src = bus_n.pc_src;
    out_n.alu_op = bus_n.alu_op; out_n.alu_sign_en = bus_n.alu_sign_en; out_n.alu_src_a = bus_n.alu_src_a;
    out_n.alu_src_b = bus_n.alu_src_b; out_n.reg_write = bus_n.reg_write; out_n.result_src = bus_n.result_src;
    out_n.retire = bus_n.retire; out_n.trap = bus_n.trap;
  end

  always_comb begin
    out_t = '0;
    out_t.mem_req = bus_t.mem_req; out_t.mem_we = bus_t.mem_we; out_t.mem_addr_src = bus_t.mem_addr_src;
    out_t.ir_write = bus_t.ir_write; out_t.pc_write = bus_t.pc_write; out_t.pc_src = bus_t.pc_src;
    out_t.alu_op = bus_t.alu_op; out_t.alu_sign_en = bus_t.alu_sign_en; out_t.alu_src_a = bus_t.alu_src_a;
    out_t.alu_src_b = bus_t.alu_src_b; out_t.reg_write = bus_t.reg_write; out_t.result_src = bus_t.result_src;
    out_t.retire = bus_t.retire; out_t.trap = bus_t.trap;
  end

  task automatic check_out(input string name, input int k, input ctrl_out_t got, input ctrl_out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, k, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic void push(input logic [6:0] op, input logic [2:0] f3, input logic flag,
                               input logic ready, input ctrl_out_t e);
    rec_t r;
    r.op = op; r.f3 = f3; r.flag = flag; r.ready = ready; r.exp = e;
    trace.push_back(r);
  endfunction

  // Expand one instruction into its expected cycles: fetch waits, fetch, decode, execute, memory, write-back.
  function automatic int add_instr(input logic [6:0] op, input logic [2:0] f3, input logic flag,
                                   input int fw, input int mw, input bit trap_mode);
    int        n0;
    ctrl_out_t e;
    bit        is_ld, is_st, legal;
    n0    = trace.size();
    is_ld = (op == OP_LOAD);
    is_st = (op == OP_STORE);
    legal = op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    for (int w = 0; w < fw; w++) begin
      e = '0; e.mem_req = 1'b1; push(op, f3, flag, 1'b0, e);
    end
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b00;
    push(op, f3, flag, 1'b1, e);
    e = '0;
    if (!legal) begin
      e.retire = !trap_mode;
      push(op, f3, flag, 1'b1, e);
      return trace.size() - n0;
    end
    push(op, f3, flag, 1'b1, e);
    e = '0;
    case (op)
      OP_R:      begin e.alu_op = 2'b10; e.alu_sign_en = 1'b1; end
      OP_I:      begin e.alu_op = 2'b10; e.alu_src_b = 1'b1; e.alu_sign_en = (f3 == 3'b101); end
      OP_LOAD, OP_STORE: begin e.alu_op = 2'b00; e.alu_src_b = 1'b1; end
      OP_BRANCH: begin e.alu_op = 2'b01; e.pc_write = flag; e.pc_src = flag ? 2'b01 : 2'b00; e.retire = 1'b1; end
      OP_JAL:    begin e.pc_write = 1'b1; e.pc_src = 2'b01; end
      OP_JALR:   begin e.alu_op = 2'b11; e.alu_src_b = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b10; end
      OP_LUI:    begin e.alu_src_a = 2'b10; e.alu_src_b = 1'b1; end
      default:   begin e.alu_src_a = 2'b01; e.alu_src_b = 1'b1; end
    endcase
    push(op, f3, flag, 1'b1, e);
    if (op == OP_BRANCH) return trace.size() - n0;
    if (is_ld || is_st) begin
      e = '0; e.mem_req = 1'b1; e.mem_addr_src = 1'b1; e.mem_we = is_st;
      for (int w = 0; w < mw; w++) push(op, f3, flag, 1'b0, e);
      e.retire = is_st;
      push(op, f3, flag, 1'b1, e);
      if (is_st) return trace.size() - n0;
    end
    e = '0; e.reg_write = 1'b1; e.retire = 1'b1;
    e.result_src = is_ld ? 2'b01 : ((op == OP_JAL || op == OP_JALR) ? 2'b10 : 2'b00);
    push(op, f3, flag, 1'b1, e);
    return trace.size() - n0;
  endfunction

  task automatic drive(input bit which, input rec_t r);
    if (which) begin
      bus_t.opcode = r.op; bus_t.func3 = r.f3; bus_t.alu_flag = r.flag; bus_t.mem_ready = r.ready;
    end else begin
      bus_n.opcode = r.op; bus_n.func3 = r.f3; bus_n.alu_flag = r.flag; bus_n.mem_ready = r.ready;
    end
  endtask

  // Replays the trace from reset release, comparing every cycle's outputs.
  task automatic run_trace(input bit which);
    ctrl_out_t got;
    for (int k = 0; k < trace.size(); k++) begin
      @(negedge clk);
      if (k == 0) rst_n = 1'b1;
      drive(which, trace[k]);
      #1;
      got = which ? out_t : out_n;
      check_out(which ? "trace_t" : "trace_n", k, got, trace[k].exp);
      if (got.retire) retires++;
    end
    trace.delete();
  endtask

  task automatic hold_reset();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    ctrl_out_t e;
    bus_n.opcode = '0; bus_n.func3 = '0; bus_n.alu_flag = 1'b0; bus_n.mem_ready = 1'b1;
    bus_t.opcode = '0; bus_t.func3 = '0; bus_t.alu_flag = 1'b0; bus_t.mem_ready = 1'b1;
    #2;
    check_out("reset_n", 0, out_n, '0);
    check_out("reset_t", 0, out_t, '0);
    hold_reset();

    c = add_instr(OP_R, 3'b000, 1'b1, 0, 0, 1'b0);
    check_int("len_sub", c, 4);
    check_int("sub_exec_aluop", int'(trace[2].exp.alu_op), 2);
    check_int("sub_exec_sign", int'(trace[2].exp.alu_sign_en), 1);
    check_int("sub_wb_regwr", int'(trace[3].exp.reg_write & trace[3].exp.retire), 1);
    c = add_instr(OP_I, 3'b000, 1'b1, 0, 0, 1'b0);
    check_int("addi_sign", int'(trace[6].exp.alu_sign_en), 0);
    c = add_instr(OP_I, 3'b101, 1'b0, 1, 0, 1'b0);
    check_int("srai_sign", int'(trace[11].exp.alu_sign_en), 1);
    c = add_instr(OP_LOAD, 3'b010, 1'b0, 0, 2, 1'b0);
    check_int("len_load_w2", c, 7);
    check_int("load_wb_res", int'(trace[trace.size()-1].exp.result_src), 1);
    c = add_instr(OP_STORE, 3'b010, 1'b1, 1, 1, 1'b0);
    check_int("len_store_w1w1", c, 6);
    c = add_instr(OP_BRANCH, 3'b000, 1'b1, 0, 0, 1'b0);
    check_int("len_beq_t", c, 3);
    check_int("beq_t_pcsrc", int'(trace[trace.size()-1].exp.pc_src), 1);
    c = add_instr(OP_BRANCH, 3'b000, 1'b0, 0, 0, 1'b0);
    check_int("beq_f_pcwr", int'(trace[trace.size()-1].exp.pc_write), 0);
    c = add_instr(OP_JAL, 3'b000, 1'b0, 0, 0, 1'b0);
    check_int("len_jal", c, 4);
    c = add_instr(OP_JALR, 3'b000, 1'b1, 0, 0, 1'b0);
    check_int("jalr_exec_aluop", int'(trace[trace.size()-2].exp.alu_op), 3);
    check_int("jalr_wb_res", int'(trace[trace.size()-1].exp.result_src), 2);
    c = add_instr(OP_LUI, 3'b000, 1'b0, 0, 0, 1'b0);
    c = add_instr(OP_AUIPC, 3'b000, 1'b0, 0, 0, 1'b0);
    c = add_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0);
    check_int("len_illegal_nop", c, 2);
    c = add_instr(OP_R, 3'b000, 1'b0, 0, 0, 1'b0);
    e = '0; e.mem_req = 1'b1;
    push(OP_LOAD, 3'b000, 1'b0, 1'b0, e);
    push(OP_LOAD, 3'b000, 1'b0, 1'b0, e);
    retires = 0;
    run_trace(1'b0);
    check_int("retire_count", retires, 13);

    #2 rst_n = 1'b0;
    #1 check_int("async_fetch_drop", int'(bus_n.mem_req), 0);
    hold_reset();

    c = add_instr(OP_LOAD, 3'b000, 1'b0, 0, 3, 1'b0);
    void'(trace.pop_back());
    void'(trace.pop_back());
    run_trace(1'b0);
    #2 rst_n = 1'b0;
    #1 check_int("async_mem_drop", int'(bus_n.mem_req), 0);
    hold_reset();

    c = add_instr(OP_R, 3'b000, 1'b0, 0, 0, 1'b1);
    c = add_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b1);
    check_int("len_illegal_trap", c, 2);
    e = '0; e.trap = 1'b1;
    for (int i = 0; i < 4; i++) push(OP_R, 3'b000, 1'b1, 1'b1, e);
    run_trace(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_int("trap_cleared", int'(bus_t.trap), 0);
    hold_reset();
    c = add_instr(OP_AUIPC, 3'b000, 1'b0, 0, 0, 1'b1);
    run_trace(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
